// File: rtl/pdm_audio_out.sv
// Audio output stage: scales and saturates 32-bit samples, holds them, and
// drives a first-order sigma-delta bit stream; mutes to mid-scale on stall.
module pdm_audio_out #(
    parameter int SAMPLE_SHIFT = 0,
    parameter int PDM_DIV      = 4,
    parameter int STALL_LIMIT  = 4608
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] audio_in,
    input  logic        audio_valid_in,
    input  logic [3:0]  volume_in,
    output logic        pdm_out,
    output logic        pdm_tick_out,
    output logic [15:0] level_out,
    output logic        clip_out,
    output logic        muted_out
);

    localparam int DIV_W   = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(PDM_DIV - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(STALL_LIMIT - 1);

    logic [DIV_W-1:0]   r_div_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic [15:0]        r_acc;

    logic signed [31:0] w_shifted;
    logic               w_hi;
    logic               w_lo;
    logic signed [15:0] w_sat;
    logic signed [15:0] w_held;
    logic [15:0]        w_u;
    logic [16:0]        w_sum;
    logic               w_tick;

    assign w_shifted = $signed(audio_in) >>> SAMPLE_SHIFT;
    assign w_hi      = w_shifted > 32'sd32767;
    assign w_lo      = w_shifted < -32'sd32768;
    assign w_sat     = w_hi ? 16'sh7FFF :
                       w_lo ? 16'sh8000 : w_shifted[15:0];
    assign w_held    = w_sat >>> volume_in;

    // Offset-binary view of the held level drives the accumulator.
    assign w_u    = {~level_out[15], level_out[14:0]};
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_u};
    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pdm_out      <= 1'b0;
            pdm_tick_out <= 1'b0;
            level_out    <= 16'h0000;
            clip_out     <= 1'b0;
            muted_out    <= 1'b1;
            r_acc        <= 16'h0000;
            r_div_cnt    <= '0;
            r_stall_cnt  <= STALL_MAX;
        end else begin
            pdm_tick_out <= w_tick;
            r_div_cnt    <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_tick) begin
                r_acc   <= w_sum[15:0];
                pdm_out <= w_sum[16];
            end

            clip_out <= audio_valid_in && (w_hi || w_lo);

            // A valid sample always beats the watchdog on the same edge.
            if (audio_valid_in) begin
                level_out   <= w_held;
                muted_out   <= 1'b0;
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != STALL_MAX) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                if (r_stall_cnt == STALL_PRE) begin
                    muted_out <= 1'b1;
                    level_out <= 16'h0000;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_audio_out.sv
// Directed bench for pdm_audio_out: reset, tick cadence, scaling,
// clipping, modulation density, stall mute and mid-stream reset.
module tb_pdm_audio_out;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] audio_in;
    logic        audio_valid_in;
    logic [3:0]  volume_in;
    logic        pdm_out;
    logic        pdm_tick_out;
    logic [15:0] level_out;
    logic        clip_out;
    logic        muted_out;

    logic [31:0] a8_in;
    logic        v8_in;
    logic        pdm8;
    logic        tick8;
    logic [15:0] level8;
    logic        clip8;
    logic        muted8;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    pdm_audio_out u_dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .audio_in       (audio_in),
        .audio_valid_in (audio_valid_in),
        .volume_in      (volume_in),
        .pdm_out        (pdm_out),
        .pdm_tick_out   (pdm_tick_out),
        .level_out      (level_out),
        .clip_out       (clip_out),
        .muted_out      (muted_out)
    );

    pdm_audio_out #(.SAMPLE_SHIFT(8)) u_dut8 (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .audio_in       (a8_in),
        .audio_valid_in (v8_in),
        .volume_in      (4'd0),
        .pdm_out        (pdm8),
        .pdm_tick_out   (tick8),
        .level_out      (level8),
        .clip_out       (clip8),
        .muted_out      (muted8)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_in         = 1'b1;
        audio_valid_in = 1'b0;
        audio_in       = 32'h0;
        volume_in      = 4'd0;
        a8_in          = 32'h0;
        v8_in          = 1'b0;

        cyc(2);
        rst_in = 1'b0;
        chk("rst_muted", 32'(muted_out), 32'd1);
        chk("rst_level", 32'(level_out), 32'h0);
        chk("rst_pdm", 32'(pdm_out), 32'd0);
        chk("rst_tick", 32'(pdm_tick_out), 32'd0);
        chk("rst_clip", 32'(clip_out), 32'd0);

        // First tick after the 4th edge; idle mid-scale alternates 0,1.
        cyc(3);
        chk("tick_e3", 32'(pdm_tick_out), 32'd0);
        cyc(1);
        chk("tick_e4", 32'(pdm_tick_out), 32'd1);
        chk("pdm_e4", 32'(pdm_out), 32'd0);
        cyc(1);
        chk("tick_e5", 32'(pdm_tick_out), 32'd0);
        cyc(3);
        chk("tick_e8", 32'(pdm_tick_out), 32'd1);
        chk("pdm_e8", 32'(pdm_out), 32'd1);

        // Full-scale positive, acc is 0 here.
        audio_valid_in = 1'b1;
        audio_in       = 32'h0000_7FFF;
        v8_in          = 1'b1;
        a8_in          = 32'h0012_3400;
        cyc(1);
        audio_valid_in = 1'b0;
        v8_in          = 1'b0;
        chk("fs_level", 32'(level_out), 32'h7FFF);
        chk("fs_clip", 32'(clip_out), 32'd0);
        chk("fs_muted", 32'(muted_out), 32'd0);
        chk("sh8_level", 32'(level8), 32'h1234);
        chk("sh8_clip", 32'(clip8), 32'd0);
        cyc(3);
        chk("fs_tick_e12", 32'(pdm_tick_out), 32'd1);
        chk("fs_pdm_e12", 32'(pdm_out), 32'd0);
        cyc(4);
        chk("fs_pdm_e16", 32'(pdm_out), 32'd1);
        cyc(4);
        chk("fs_pdm_e20", 32'(pdm_out), 32'd1);

        // Clipping, back to back.
        audio_valid_in = 1'b1;
        audio_in       = 32'h0001_0000;
        v8_in          = 1'b1;
        a8_in          = 32'h7FFF_FFFF;
        cyc(1);
        v8_in = 1'b0;
        chk("clip_pos_level", 32'(level_out), 32'h7FFF);
        chk("clip_pos", 32'(clip_out), 32'd1);
        chk("sh8_clip_level", 32'(level8), 32'h7FFF);
        chk("sh8_clip_pulse", 32'(clip8), 32'd1);
        audio_in = 32'hFFFF_0000;
        cyc(1);
        audio_valid_in = 1'b0;
        chk("clip_neg_level", 32'(level_out), 32'h8000);
        chk("clip_neg", 32'(clip_out), 32'd1);
        cyc(1);
        chk("clip_drop", 32'(clip_out), 32'd0);
        cyc(1);
        chk("neg_tick_e24", 32'(pdm_tick_out), 32'd1);
        chk("neg_pdm_e24", 32'(pdm_out), 32'd0);
        cyc(4);
        chk("neg_pdm_e28", 32'(pdm_out), 32'd0);

        // Volume attenuation.
        audio_valid_in = 1'b1;
        audio_in       = 32'h0000_4000;
        volume_in      = 4'd2;
        cyc(1);
        chk("vol_pos", 32'(level_out), 32'h1000);
        chk("vol_pos_clip", 32'(clip_out), 32'd0);
        audio_in = 32'hFFFF_C000;
        cyc(1);
        chk("vol_neg", 32'(level_out), 32'hF000);
        audio_in  = 32'h8000_0000;
        volume_in = 4'd15;
        cyc(1);
        audio_valid_in = 1'b0;
        volume_in      = 4'd0;
        chk("vol15_level", 32'(level_out), 32'hFFFF);
        chk("vol15_clip", 32'(clip_out), 32'd1);

        // Stall watchdog.
        cyc(4607);
        chk("stall_pre_muted", 32'(muted_out), 32'd0);
        chk("stall_pre_level", 32'(level_out), 32'hFFFF);
        cyc(1);
        chk("stall_muted", 32'(muted_out), 32'd1);
        chk("stall_level", 32'(level_out), 32'h0);

        // Valid on the would-be mute edge wins.
        audio_valid_in = 1'b1;
        audio_in       = 32'h0000_1234;
        cyc(1);
        audio_valid_in = 1'b0;
        chk("unmute_level", 32'(level_out), 32'h1234);
        chk("unmute_muted", 32'(muted_out), 32'd0);
        cyc(4607);
        audio_valid_in = 1'b1;
        audio_in       = 32'h0000_2000;
        cyc(1);
        audio_valid_in = 1'b0;
        chk("race_level", 32'(level_out), 32'h2000);
        chk("race_muted", 32'(muted_out), 32'd0);
        cyc(1);
        chk("race_hold_muted", 32'(muted_out), 32'd0);
        chk("race_hold_level", 32'(level_out), 32'h2000);

        // Mid-stream reset with a sample presented on the reset edge.
        rst_in         = 1'b1;
        audio_valid_in = 1'b1;
        audio_in       = 32'h7FFF_FFFF;
        cyc(1);
        rst_in         = 1'b0;
        audio_valid_in = 1'b0;
        chk("mrst_level", 32'(level_out), 32'h0);
        chk("mrst_muted", 32'(muted_out), 32'd1);
        chk("mrst_clip", 32'(clip_out), 32'd0);
        chk("mrst_tick", 32'(pdm_tick_out), 32'd0);
        chk("mrst_pdm", 32'(pdm_out), 32'd0);
        cyc(3);
        chk("mrst_tick_e3", 32'(pdm_tick_out), 32'd0);
        cyc(1);
        chk("mrst_tick_e4", 32'(pdm_tick_out), 32'd1);
        chk("mrst_pdm_e4", 32'(pdm_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pdm_audio_out.md
# pdm_audio_out

Final audio output stage: consumes the 32-bit corrected-audio sample stream produced by the buffering/PSOLA stage (one sample per playback period) and drives a 1-bit first-order sigma-delta (PDM) output suitable for an RC-filtered speaker pin. It scales and saturates each sample, holds it between arrivals, and mutes to mid-scale if the upstream stream stalls.

## Interface
- SAMPLE_SHIFT, 0: arithmetic right shift applied to the 32-bit input before saturation to 16 bits.
- PDM_DIV, 4: clock cycles per PDM output bit (≥2).
- STALL_LIMIT, 4608: cycles without audio_valid_in before muting.

- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- audio_in  input  32  signed sample from the upstream stage.
- audio_valid_in  input  1  single-cycle strobe; audio_in is sampled when high.
- volume_in  input  4  attenuation (arithmetic right shift 0..15), sampled with each accepted sample.
- pdm_out  output  1  sigma-delta bit stream.
- pdm_tick_out  output  1  one-cycle pulse in the cycle pdm_out shows a new bit.
- level_out  output  16  signed held sample currently being modulated.
- clip_out  output  1  one-cycle pulse: last accepted sample saturated.
- muted_out  output  1  high while the stream is stalled (or no sample since reset).

## Operation
- Accept path (on audio_valid_in): s = audio_in >>> SAMPLE_SHIFT (arithmetic); sat = clamp(s, -32768, 32767); held = sat >>> volume_in (arithmetic). held registered into level_out.
- clip_out pulses with the level_out update iff clamping changed the value.
- Modulator: u = level_out with MSB inverted (offset binary, 0..65535). 16-bit accumulator acc plus carry: on each PDM tick {carry, acc} = acc + u; pdm_out = carry. Long-run density of 1s = u/65536.
- Divider: div_cnt counts 0..PDM_DIV-1 and wraps; a tick occurs at the edge where div_cnt == PDM_DIV-1. Ticks run continuously, independent of samples.
- Stall watchdog: stall_cnt cleared by audio_valid_in, otherwise increments, saturating at STALL_LIMIT. When it reaches STALL_LIMIT: muted_out=1, level_out forced to 0 (50% density); acc is not cleared.
- An accepted sample clears muted_out in the same edge that loads level_out.

## Timing
- Reset values: pdm_out=0, pdm_tick_out=0, level_out=0, clip_out=0, muted_out=1, acc=0, div_cnt=0, stall_cnt=STALL_LIMIT.
- Sample latency: audio_valid_in high in cycle T → level_out, clip_out, muted_out updated in cycle T+1.
- A tick uses the registered level_out at that edge; a sample loaded on the same edge as a tick affects only the following tick.
- pdm_tick_out is high for exactly one cycle every PDM_DIV cycles; first assertion is in the cycle after the PDM_DIV-th rising edge following rst_in deassertion; pdm_out changes only in those cycles.
- Simultaneous valid and stall_cnt reaching STALL_LIMIT: valid wins, muted_out stays 0, new sample loads.
- Back-to-back valids accepted every cycle; each overwrites level_out.
- Reset mid-stream returns all state to reset values on the next edge; no partial sample survives.
- Width rules: shifts on signed 32-bit; clamp before attenuation; accumulator add is 17-bit unsigned.

## Test plan
- Reset then no input: muted_out=1, level_out=0, pdm_out alternates 0,1,0,1 on successive ticks; tick period = PDM_DIV cycles.
- audio_in=0x00007FFF, volume 0: level_out=32767 at T+1, clip_out=0, muted_out falls; after first tick pdm_out=1 on 65535 of every 65536 ticks (first tick 0, then 1s).
- audio_in=0x00010000 → level_out=0x7FFF, clip_out pulse; audio_in=0xFFFF0000 → level_out=0x8000, clip_out pulse, pdm_out stays 0.
- audio_in=0x00004000, volume_in=2 → level_out=0x1000; SAMPLE_SHIFT=8 build with audio_in=0x00123400 → level_out=0x1234, no clip.
- One sample, then idle STALL_LIMIT cycles → muted_out=1 and level_out=0 exactly STALL_LIMIT cycles after last valid; valid arriving that same cycle → no mute.
- Assert rst_in mid-stream with level_out≠0 → next cycle all outputs at reset values; tick phase restarts.
